// File: rtl/grf_pkg.sv
// -----------------------------------------------------------------------------
// grf_pkg
// Shared definitions for the GRF write-port arbiter and its result FIFO.
//   REG_AW   : register address width
//   DATA_W   : register data / PC width
//   NREG     : number of architectural registers (width of the pending mask)
//   wb_req_t : one queued write-back request {a3, wd, pc}
//   a3_onehot: decodes a destination register into a pending-mask bit
//              ($0 never produces a bit)
// -----------------------------------------------------------------------------
package grf_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_req_t;

    function automatic logic [NREG-1:0] a3_onehot(input logic [REG_AW-1:0] a3);
        logic [NREG-1:0] v;
        v = {NREG{1'b0}};
        if (a3 != {REG_AW{1'b0}}) begin
            v[a3] = 1'b1;
        end else begin
            v = {NREG{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/grf_wport_arbiter_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry queue of MDU write-back requests. Every occupied slot carries a
// valid bit; clearing it (kill) squashes the entry without freeing the slot.
// After each update the read pointer is advanced past squashed slots, so
// whenever the queue is non-empty its head is a live entry.
//   clk, reset      : clock, asynchronous active-low reset
//   push_i/push_req_i : enqueue request (caller guarantees !full_o)
//   pop_i           : dequeue the head (caller guarantees head_vld_o)
//   kill_i          : per-slot squash mask
//   cmp_a3_i        : register compared against every live entry
//   cmp_hit_o       : per-slot match of cmp_a3_i against live entries
//   head_vld_o/head_o : live head entry
//   full_o          : all slots occupied
//   entry_vld_o/entry_a3_o : per-slot valid bit and destination register
// -----------------------------------------------------------------------------
module wb_fifo
    import grf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  wb_req_t                       push_req_i,
    input  logic                          pop_i,
    input  logic [DEPTH-1:0]              kill_i,
    input  logic [REG_AW-1:0]             cmp_a3_i,
    output logic [DEPTH-1:0]              cmp_hit_o,
    output logic                          head_vld_o,
    output wb_req_t                       head_o,
    output logic                          full_o,
    output logic [DEPTH-1:0]              entry_vld_o,
    output logic [DEPTH-1:0][REG_AW-1:0]  entry_a3_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0]           rd_q, rd_d;
    logic [PW-1:0]           wr_q, wr_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    wb_req_t [DEPTH-1:0]     mem_q, mem_d;
    logic                    empty_s;

    assign empty_s    = (rd_q == wr_q);
    assign full_o     = (rd_q[PW-1] != wr_q[PW-1]) && (rd_q[IW-1:0] == wr_q[IW-1:0]);
    assign head_vld_o = !empty_s && vld_q[rd_q[IW-1:0]];
    assign head_o     = mem_q[rd_q[IW-1:0]];
    assign entry_vld_o = vld_q;

    // Per-slot destination export and compare port
    always_comb begin
        cmp_hit_o  = {DEPTH{1'b0}};
        entry_a3_o = {(DEPTH*REG_AW){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            entry_a3_o[i] = mem_q[i].a3;
            cmp_hit_o[i]  = vld_q[i] && (mem_q[i].a3 == cmp_a3_i);
        end
    end

    // Next state: squash, pop, push, then skip squashed slots at the head
    always_comb begin
        vld_d = vld_q & ~kill_i;
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (pop_i) begin
            vld_d[rd_q[IW-1:0]] = 1'b0;
            rd_d                = rd_q + PTR_ONE;
        end else begin
            rd_d = rd_q;
        end
        if (push_i) begin
            mem_d[wr_q[IW-1:0]] = push_req_i;
            vld_d[wr_q[IW-1:0]] = 1'b1;
            wr_d                = wr_q + PTR_ONE;
        end else begin
            wr_d = wr_q;
        end
        // At most DEPTH squashed slots can sit in front of a live entry
        for (int k = 0; k < DEPTH; k++) begin
            if ((rd_d != wr_d) && !vld_d[rd_d[IW-1:0]]) begin
                rd_d = rd_d + PTR_ONE;
            end else begin
                rd_d = rd_d;
            end
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= {PW{1'b0}};
            wr_q  <= {PW{1'b0}};
            vld_q <= {DEPTH{1'b0}};
            mem_q <= {(DEPTH*$bits(wb_req_t)){1'b0}};
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            vld_q <= vld_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/grf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// grf_wport_arbiter
// Shares the single GRF write port between the W stage (always wins, never
// stalled) and queued MDU results, which drain into idle W slots.
//   clk, reset                          : clock, async active-low reset
//   W_RegWrite/W_GRF_A3/W_GRF_WD/W_PC   : W-stage write request
//   md_valid/md_ready/md_a3/md_wd/md_pc : MDU result handshake
//   grf_we/grf_a3/grf_wd/grf_pc         : GRF write port (combinational)
//   pend_mask : registers targeted by live queued entries
//   stall_req : head has waited STARVE_MAX cycles; asks for a W bubble
//   waw_drop  : a queued entry was squashed by a W write to its register
// -----------------------------------------------------------------------------
module grf_wport_arbiter
    import grf_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_RegWrite,
    input  logic [REG_AW-1:0] W_GRF_A3,
    input  logic [DATA_W-1:0] W_GRF_WD,
    input  logic [DATA_W-1:0] W_PC,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_AW-1:0] md_a3,
    input  logic [DATA_W-1:0] md_wd,
    input  logic [DATA_W-1:0] md_pc,
    output logic              grf_we,
    output logic [REG_AW-1:0] grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc,
    output logic [NREG-1:0]   pend_mask,
    output logic              stall_req,
    output logic              waw_drop
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic                         w_busy_s;
    logic                         push_s;
    logic                         pop_s;
    logic [DEPTH-1:0]             kill_s;
    logic [DEPTH-1:0]             cmp_hit_s;
    logic                         head_vld_s;
    wb_req_t                      head_s;
    wb_req_t                      push_req_s;
    logic                         full_s;
    logic [DEPTH-1:0]             entry_vld_s;
    logic [DEPTH-1:0][REG_AW-1:0] entry_a3_s;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall_q, stall_d;
    logic          waw_q, waw_d;

    assign w_busy_s   = W_RegWrite && (W_GRF_A3 != 5'd0);
    // Gated by reset so the handshake reads as idle while reset is held
    assign md_ready   = reset && !full_s;
    // $0 results complete the handshake but are never queued
    assign push_s     = md_valid && md_ready && (md_a3 != 5'd0);
    assign pop_s      = !w_busy_s && head_vld_s;
    // A W write supersedes any queued write to the same register
    assign kill_s     = w_busy_s ? cmp_hit_s : {DEPTH{1'b0}};
    assign push_req_s = '{a3: md_a3, wd: md_wd, pc: md_pc};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_s),
        .push_req_i  (push_req_s),
        .pop_i       (pop_s),
        .kill_i      (kill_s),
        .cmp_a3_i    (W_GRF_A3),
        .cmp_hit_o   (cmp_hit_s),
        .head_vld_o  (head_vld_s),
        .head_o      (head_s),
        .full_o      (full_s),
        .entry_vld_o (entry_vld_s),
        .entry_a3_o  (entry_a3_s)
    );

    // Write-port mux: W first, then FIFO head, else idle; forced idle in reset
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = {REG_AW{1'b0}};
        grf_wd = {DATA_W{1'b0}};
        grf_pc = {DATA_W{1'b0}};
        if (!reset) begin
            grf_we = 1'b0;
        end else if (w_busy_s) begin
            grf_we = 1'b1;
            grf_a3 = W_GRF_A3;
            grf_wd = W_GRF_WD;
            grf_pc = W_PC;
        end else if (head_vld_s) begin
            grf_we = 1'b1;
            grf_a3 = head_s.a3;
            grf_wd = head_s.wd;
            grf_pc = head_s.pc;
        end else begin
            grf_we = 1'b0;
        end
    end

    // Pending-write mask decoded from live entries
    always_comb begin
        pend_mask = {NREG{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld_s[i]) begin
                pend_mask = pend_mask | a3_onehot(entry_a3_s[i]);
            end else begin
                pend_mask = pend_mask;
            end
        end
    end

    // Starvation counter, stall request and WAW pulse next state
    always_comb begin
        cnt_d   = cnt_q;
        stall_d = stall_q;
        waw_d   = w_busy_s && (|cmp_hit_s);
        if (!head_vld_s || pop_s) begin
            cnt_d   = {CW{1'b0}};
            stall_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = cnt_q;
            stall_d = 1'b1;
        end else begin
            cnt_d   = cnt_q + CNT_ONE;
            stall_d = stall_q;
        end
    end

    // Starvation / stall / WAW registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= {CW{1'b0}};
            stall_q <= 1'b0;
            waw_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            waw_q   <= waw_d;
        end
    end

    assign stall_req = stall_q;
    assign waw_drop  = waw_q;

endmodule

// File: tb/tb_grf_wport_arbiter.sv
module tb_grf_wport_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        W_RegWrite;
    logic [4:0]  W_GRF_A3;
    logic [31:0] W_GRF_WD;
    logic [31:0] W_PC;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_a3;
    logic [31:0] md_wd;
    logic [31:0] md_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [31:0] pend_mask;
    logic        stall_req;
    logic        waw_drop;

    grf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .W_RegWrite(W_RegWrite), .W_GRF_A3(W_GRF_A3), .W_GRF_WD(W_GRF_WD), .W_PC(W_PC),
        .md_valid(md_valid), .md_ready(md_ready), .md_a3(md_a3), .md_wd(md_wd), .md_pc(md_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .pend_mask(pend_mask), .stall_req(stall_req), .waw_drop(waw_drop)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: ordered list of accepted MDU writes, each still live or
    // squashed; squashed writes at the front are discarded right away.
    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        bit          alive;
    } ment_t;
    ment_t mq[$];
    int    m_wait;   // cycles the current head has been waiting (saturating)
    bit    m_stall;
    bit    m_waw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_wait  = 0;
        m_stall = 0;
        m_waw   = 0;
    endtask

    // Compare every output against what the model says for the current inputs
    task automatic check_all();
        bit          wbusy;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd, e_pc, e_pend;
        wbusy = W_RegWrite && (W_GRF_A3 != 5'd0);
        e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0; e_pc = 32'd0;
        if (wbusy) begin
            e_we = 1'b1; e_a3 = W_GRF_A3; e_wd = W_GRF_WD; e_pc = W_PC;
        end else if (mq.size() > 0) begin
            e_we = 1'b1; e_a3 = mq[0].a3; e_wd = mq[0].wd; e_pc = mq[0].pc;
        end
        e_pend = 32'd0;
        foreach (mq[i]) if (mq[i].alive) e_pend[mq[i].a3] = 1'b1;
        chk("grf_we", grf_we, e_we);
        chk("grf_a3", grf_a3, e_a3);
        chk("grf_wd", grf_wd, e_wd);
        chk("grf_pc", grf_pc, e_pc);
        chk("md_ready", md_ready, (mq.size() < DEPTH));
        chk("pend_mask", pend_mask, e_pend);
        chk("stall_req", stall_req, m_stall);
        chk("waw_drop", waw_drop, m_waw);
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        bit wbusy, head, pop, hit, acc;
        wbusy = W_RegWrite && (W_GRF_A3 != 5'd0);
        head  = (mq.size() > 0);
        pop   = !wbusy && head;
        acc   = md_valid && (mq.size() < DEPTH) && (md_a3 != 5'd0);
        hit   = 0;
        if (wbusy) begin
            foreach (mq[i]) begin
                if (mq[i].alive && mq[i].a3 == W_GRF_A3) begin
                    mq[i].alive = 0;
                    hit = 1;
                end
            end
        end
        if (!head || pop) begin
            m_wait  = 0;
            m_stall = 0;
        end else begin
            if (m_wait == STARVE_MAX) m_stall = 1;
            m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
        end
        m_waw = hit;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back('{a3: md_a3, wd: md_wd, pc: md_pc, alive: 1'b1});
        while (mq.size() > 0 && !mq[0].alive) void'(mq.pop_front());
    endtask

    // One clock cycle: apply inputs, check mid-cycle, clock model and DUT
    task automatic step(input logic wwe, input logic [4:0] wa3, input logic [31:0] wwd,
                        input logic mv, input logic [4:0] ma3, input logic [31:0] mwd);
        W_RegWrite = wwe; W_GRF_A3 = wa3; W_GRF_WD = wwd; W_PC = 32'h1000 + {27'd0, wa3};
        md_valid = mv; md_a3 = ma3; md_wd = mwd; md_pc = 32'h2000 + {27'd0, ma3};
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        W_RegWrite = 1'b0; W_GRF_A3 = 5'd0; W_GRF_WD = 32'd0; W_PC = 32'd0;
        md_valid = 1'b0; md_a3 = 5'd0; md_wd = 32'd0; md_pc = 32'd0;
        model_clear();
        #1;
        chk("rst_grf_we", grf_we, 1'b0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_waw", waw_drop, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // W priority: W $5<-0x11 while MDU pushes $6<-0x22, then W idle
        step(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
        W_RegWrite = 1'b0; md_valid = 1'b0;
        @(negedge clk);
        chk("prio_c1_a3", grf_a3, 5'd6);
        chk("prio_c1_wd", grf_wd, 32'h22);
        chk("prio_c1_pend6", pend_mask[6], 1'b1);
        @(posedge clk); model_edge(); #1;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("prio_c2_pend6", pend_mask[6], 1'b0);

        // Full FIFO: two pushes under continuous W writes, third held off
        step(1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'hA0);
        step(1'b1, 5'd2, 32'h102, 1'b1, 5'd11, 32'hA1);
        step(1'b1, 5'd3, 32'h103, 1'b1, 5'd12, 32'hA2);
        chk("full_ready_low", md_ready, 1'b0);
        step(1'b0, 5'd0, 32'd0,   1'b1, 5'd12, 32'hA2);
        step(1'b1, 5'd3, 32'h104, 1'b1, 5'd12, 32'hA2);
        idle(3);

        // Starvation: one entry, W busy continuously, then one idle slot
        step(1'b1, 5'd1, 32'h201, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 7; i++) step(1'b1, 5'd2, 32'h300 + i, 1'b0, 5'd0, 32'd0);
        chk("starve_stall_hi", stall_req, 1'b1);
        idle(2);
        chk("starve_stall_lo", stall_req, 1'b0);

        // WAW: queue $8<-0xAA, then W writes $8<-0xBB
        step(1'b1, 5'd1, 32'h301, 1'b1, 5'd8, 32'hAA);
        step(1'b1, 5'd8, 32'hBB, 1'b0, 5'd0, 32'd0);
        chk("waw_pulse", waw_drop, 1'b1);
        chk("waw_pend8", pend_mask[8], 1'b0);
        idle(3);

        // $0 result: handshake accepted, nothing queued or written
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        idle(2);

        // Async reset mid-cycle with two entries queued and stall_req high
        step(1'b1, 5'd1, 32'h401, 1'b1, 5'd20, 32'hC0);
        step(1'b1, 5'd1, 32'h402, 1'b1, 5'd21, 32'hC1);
        for (int i = 0; i < 6; i++) step(1'b1, 5'd3, 32'h500 + i, 1'b0, 5'd0, 32'd0);
        chk("pre_rst_stall", stall_req, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_grf_we", grf_we, 1'b0);
        chk("arst_grf_a3", grf_a3, 5'd0);
        chk("arst_grf_wd", grf_wd, 32'd0);
        chk("arst_pend", pend_mask, 32'd0);
        chk("arst_stall", stall_req, 1'b0);
        chk("arst_waw", waw_drop, 1'b0);
        chk("arst_ready", md_ready, 1'b0);
        model_clear();
        W_RegWrite = 1'b0; md_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        // Random traffic over a small register range to provoke WAW cases
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
